oled_i2c_target: RTL and testbench

- I2C target (responder) that models the receive side of an SSD1306 128x32 OLED on the shared SDA/SCL bus.
- Detects START/STOP and matches the 7-bit address.
- Parses SSD1306 control bytes (Co, D/C#) and presents each received command or GDDRAM byte on a parallel strobe interface.
- Used as the bus-functional counterpart of the OLED I2C master in simulation, and as an on-chip display-capture/mirror target in hardware.

---
 rtl/oled_i2c_target_if.sv | 18 +
 rtl/oled_i2c_target.sv | 171 +++++++++++++++++
 tb/tb_oled_i2c_target.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_i2c_target_if.sv
// Parallel byte-strobe bundle between oled_i2c_target (master side) and its consumer.
interface oled_i2c_target_if #(
  parameter int unsigned CNT_W = 10
);
  logic             byte_valid;
  logic [7:0]       byte_out;
  logic             byte_is_data;
  logic [CNT_W-1:0] byte_count;
  logic             busy;
  logic             nack_event;

  modport master (
    output byte_valid, byte_out, byte_is_data, byte_count, busy, nack_event
  );
  modport slave (
    input  byte_valid, byte_out, byte_is_data, byte_count, busy, nack_event
  );
endinterface

// File: rtl/oled_i2c_target.sv
// I2C write-only target modelling the SSD1306 receive side; emits command/GDDRAM byte strobes.
// Define OLED_I2C_GLITCH_FILTER_EN to add a 3-sample majority filter on scl/sda.
module oled_i2c_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned CNT_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  oled_i2c_target_if.master stream
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StCtrl, StCtrlAck, StPayload, StPayloadAck, StIgnore
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
    end
  end

`ifdef OLED_I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
    end
  end

  assign scl_c = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[1] & scl_hist_q[2]) |
                 (scl_hist_q[0] & scl_hist_q[2]);
  assign sda_c = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[1] & sda_hist_q[2]) |
                 (sda_hist_q[0] & sda_hist_q[2]);
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q & ~sda_c & sda_prev_q;
  assign stop_det  = scl_c & scl_prev_q & sda_c & ~sda_prev_q;

  state_e           state_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             co_q, dc_q;
  logic             sda_oe_q;
  logic             byte_valid_q, byte_is_data_q, busy_q, nack_q;
  logic [7:0]       byte_out_q;
  logic [CNT_W-1:0] byte_count_q;
  logic             byte_done;

  assign byte_done = (bit_cnt_q == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      co_q           <= 1'b0;
      dc_q           <= 1'b0;
      sda_oe_q       <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_out_q     <= '0;
      byte_is_data_q <= 1'b0;
      byte_count_q   <= '0;
      busy_q         <= 1'b0;
      nack_q         <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      nack_q       <= 1'b0;
      // Count advances the cycle after the strobe so byte_count matches byte_out while valid.
      if (byte_valid_q && (byte_count_q != {CNT_W{1'b1}})) begin
        byte_count_q <= byte_count_q + 1'b1;
      end
      if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          StAddr, StCtrl, StPayload: begin
            if (scl_rise && !byte_done) begin
              shift_q   <= {shift_q[6:0], sda_c};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (scl_fall && byte_done) begin
              bit_cnt_q <= '0;
              if (state_q == StAddr) begin
                if ((shift_q[7:1] == SLAVE_ADDR) && !shift_q[0]) begin
                  sda_oe_q <= 1'b1;
                  state_q  <= StAddrAck;
                end else begin
                  nack_q  <= 1'b1;
                  state_q <= StIgnore;
                end
              end else if (state_q == StCtrl) begin
                co_q     <= shift_q[7];
                dc_q     <= shift_q[6];
                sda_oe_q <= 1'b1;
                state_q  <= StCtrlAck;
              end else begin
                byte_out_q     <= shift_q;
                byte_is_data_q <= dc_q;
                byte_valid_q   <= 1'b1;
                sda_oe_q       <= 1'b1;
                state_q        <= StPayloadAck;
              end
            end
          end
          StAddrAck, StCtrlAck, StPayloadAck: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              if (state_q == StAddrAck) begin
                state_q      <= StCtrl;
                busy_q       <= 1'b1;
                byte_count_q <= '0;
              end else if (state_q == StCtrlAck) begin
                state_q <= StPayload;
              end else begin
                state_q <= co_q ? StCtrl : StPayload;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign stream.byte_valid   = byte_valid_q;
  assign stream.byte_out     = byte_out_q;
  assign stream.byte_is_data = byte_is_data_q;
  assign stream.byte_count   = byte_count_q;
  assign stream.busy         = busy_q;
  assign stream.nack_event   = nack_q;

endmodule

// File: tb/tb_oled_i2c_target.sv
// Self-checking bench for oled_i2c_target: bit-banged I2C master, transaction-level model.
module tb_oled_i2c_target;

  localparam logic [6:0]  SlaveAddr = 7'h3C;
  localparam int unsigned CntW      = 3;
  localparam int          MaxCnt    = (1 << CntW) - 1;
  localparam int          Half      = 16;
  localparam int          Q         = 8;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic scl_drv    = 1'b1;
  logic tb_sda_low = 1'b0;
  logic ack_window = 1'b0;
  logic cur_ack    = 1'b0;
  wire  sda;

  assign sda = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  oled_i2c_target_if #(.CNT_W(CntW)) stream_if ();

  oled_i2c_target #(
    .SLAVE_ADDR(SlaveAddr),
    .CNT_W     (CntW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl_drv),
    .sda   (sda),
    .stream(stream_if)
  );

  typedef struct packed {
    logic [7:0]      b;
    logic            dc;
    logic [CntW-1:0] cnt;
  } strobe_t;

  strobe_t    exp_q[$];
  int         exp_nack = 0;
  logic [7:0] last_out = 8'h00;
  logic       last_dc  = 1'b0;
  logic [7:0] txq[$];
  int         n_pass   = 0;
  int         n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  function automatic logic [CntW-1:0] sat(input int i);
    return (i > MaxCnt) ? CntW'(MaxCnt) : CntW'(i);
  endfunction

  function automatic void push_exp(input logic [7:0] b, input logic dc, input int cnt);
    exp_q.push_back('{b: b, dc: dc, cnt: CntW'(cnt)});
  endfunction

  // Transaction-level model: which payload bytes must be strobed for the bytes in txq.
  function automatic void model_txn();
    logic co, dc;
    bit   in_ctrl;
    int   idx;
    if ((txq[0][7:1] != SlaveAddr) || txq[0][0]) begin
      exp_nack++;
      return;
    end
    in_ctrl = 1'b1;
    co      = 1'b0;
    dc      = 1'b0;
    idx     = 0;
    for (int i = 1; i < txq.size(); i++) begin
      if (in_ctrl) begin
        co      = txq[i][7];
        dc      = txq[i][6];
        in_ctrl = 1'b0;
      end else begin
        exp_q.push_back('{b: txq[i], dc: dc, cnt: sat(idx)});
        idx++;
        in_ctrl = co;
      end
    end
  endfunction

  // Per-cycle compare against the model, sampled 1 unit after the active edge.
  initial begin
    strobe_t e;
    forever begin
      @(posedge clk);
      #1;
      if (stream_if.byte_valid) begin
        if (exp_q.size() == 0) begin
          check("byte_valid_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("byte_out", stream_if.byte_out, e.b);
          check("byte_is_data", stream_if.byte_is_data, e.dc);
          check("byte_count", stream_if.byte_count, e.cnt);
          last_out = e.b;
          last_dc  = e.dc;
        end
      end else begin
        check("byte_out_hold", stream_if.byte_out, last_out);
        check("byte_is_data_hold", stream_if.byte_is_data, last_dc);
      end
      if (stream_if.nack_event) begin
        check("nack_event", 1, (exp_nack > 0) ? 1 : 0);
        if (exp_nack > 0) exp_nack--;
      end
      if (!tb_sda_low && !(ack_window && cur_ack)) check("sda_released", sda, 1);
    end
  end

  task automatic send_bit(input logic b);
    repeat (Q) @(negedge clk);
    ack_window = 1'b0;
    tb_sda_low = ~b;
    repeat (Half - Q) @(negedge clk);
    scl_drv = 1'b1;
    repeat (Half) @(negedge clk);
    scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    cur_ack    = ack;
    ack_window = 1'b1;
    repeat (Q) @(negedge clk);
    tb_sda_low = 1'b0;
    repeat (Half - Q) @(negedge clk);
    scl_drv = 1'b1;
    repeat (Half / 2) @(negedge clk);
    check("ack_bit", sda, ack ? 0 : 1);
    repeat (Half / 2) @(negedge clk);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl_drv) begin
      repeat (Q) @(negedge clk);
      ack_window = 1'b0;
      tb_sda_low = 1'b0;
      repeat (Half - Q) @(negedge clk);
      scl_drv = 1'b1;
      repeat (Half) @(negedge clk);
    end
    tb_sda_low = 1'b1;
    repeat (Half) @(negedge clk);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    repeat (Q) @(negedge clk);
    ack_window = 1'b0;
    tb_sda_low = 1'b1;
    repeat (Half - Q) @(negedge clk);
    scl_drv = 1'b1;
    repeat (Half) @(negedge clk);
    tb_sda_low = 1'b0;
    repeat (Half) @(negedge clk);
  endtask

  // Sends txq, then `partial` leading bits of pbits, then STOP if requested.
  task automatic run_txn(input int partial, input logic [7:0] pbits, input bit do_stop);
    logic match;
    match = (txq[0][7:1] == SlaveAddr) && !txq[0][0];
    i2c_start();
    send_byte(txq[0], match);
    repeat (Q) @(negedge clk);
    check("busy_after_addr", stream_if.busy, match);
    for (int i = 1; i < txq.size(); i++) send_byte(txq[i], match);
    for (int i = 0; i < partial; i++) send_bit(pbits[7-i]);
    check("strobes_pending", exp_q.size(), 0);
    check("nack_pending", exp_nack, 0);
    exp_q.delete();
    exp_nack = 0;
    if (do_stop) begin
      i2c_stop();
      check("busy_after_stop", stream_if.busy, 0);
    end
  endtask

  task automatic reset_during_ack();
    txq = '{8'h78};
    i2c_start();
    send_byte(8'h78, 1'b1);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    cur_ack    = 1'b1;
    ack_window = 1'b1;
    repeat (Q) @(negedge clk);
    tb_sda_low = 1'b0;
    repeat (2) @(negedge clk);
    check("ack_before_reset", sda, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack_sda", sda, 1);
    check("rst_mid_ack_busy", stream_if.busy, 0);
    check("rst_mid_ack_count", stream_if.byte_count, 0);
    check("rst_mid_ack_valid", stream_if.byte_valid, 0);
    ack_window = 1'b0;
    last_out   = 8'h00;
    last_dc    = 1'b0;
    exp_q.delete();
    exp_nack = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    i2c_stop();
    check("busy_after_reset_stop", stream_if.busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int   sat_cnt[10];
    logic [7:0] addr;
    int   nb, partial;
    bit   do_stop;

    sat_cnt = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    repeat (4) @(negedge clk);
    check("rst_sda", sda, 1);
    check("rst_byte_valid", stream_if.byte_valid, 0);
    check("rst_byte_out", stream_if.byte_out, 0);
    check("rst_byte_is_data", stream_if.byte_is_data, 0);
    check("rst_byte_count", stream_if.byte_count, 0);
    check("rst_busy", stream_if.busy, 0);
    check("rst_nack_event", stream_if.nack_event, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Hand-computed expectations.
    push_exp(8'hAE, 1'b0, 0);
    push_exp(8'hD5, 1'b0, 1);
    txq = '{8'h78, 8'h00, 8'hAE, 8'hD5};
    run_txn(0, 8'h00, 1'b1);

    push_exp(8'hFF, 1'b1, 0);
    push_exp(8'h00, 1'b1, 1);
    push_exp(8'h81, 1'b1, 2);
    txq = '{8'h78, 8'h40, 8'hFF, 8'h00, 8'h81};
    run_txn(0, 8'h00, 1'b1);

    push_exp(8'hAF, 1'b0, 0);
    push_exp(8'h55, 1'b1, 1);
    txq = '{8'h78, 8'h80, 8'hAF, 8'hC0, 8'h55};
    run_txn(0, 8'h00, 1'b1);

    exp_nack = 1;
    txq = '{8'h7A, 8'h00};
    run_txn(0, 8'h00, 1'b1);

    exp_nack = 1;
    txq = '{8'h79};
    run_txn(0, 8'h00, 1'b1);

    txq = '{8'h78, 8'h00};
    run_txn(4, 8'hA0, 1'b0);
    push_exp(8'h8D, 1'b0, 0);
    txq = '{8'h78, 8'h00, 8'h8D};
    run_txn(0, 8'h00, 1'b1);

    txq = '{8'h78, 8'h00};
    for (int i = 0; i < 10; i++) begin
      txq.push_back(8'h30 + 8'(i));
      push_exp(8'h30 + 8'(i), 1'b0, sat_cnt[i]);
    end
    run_txn(0, 8'h00, 1'b1);

    reset_during_ack();

    // Randomized transactions checked against the model.
    for (int t = 0; t < 25; t++) begin
      txq.delete();
      nb = $urandom_range(0, 9);
      if (nb < 7)       addr = 8'h78;
      else if (nb == 7) addr = 8'h79;
      else              addr = {7'($urandom_range(0, 127)), 1'b0};
      txq.push_back(addr);
      nb = $urandom_range(0, 5);
      for (int i = 0; i < nb; i++) txq.push_back(8'($urandom_range(0, 255)));
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      do_stop = ($urandom_range(0, 2) != 0);
      model_txn();
      run_txn(partial, 8'($urandom_range(0, 255)), do_stop);
    end
    if (scl_drv == 1'b0) i2c_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
